if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 124 ++++++++++++
 tb/tb_if_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time, feeds IF/ID.
// Optional misaligned-redirect trap under `IF_MISALIGN_TRAP_EN (adds fault_o and a sticky FAULT state).
module if_fetch_unit #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_PC  = '0,
  parameter logic [N-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [N-1:0] redirect_pc_i,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic         imem_ready_i,
  input  logic [N-1:0] imem_rdata_i,
  output logic         valid_o,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] instr_o,
`ifdef IF_MISALIGN_TRAP_EN
  output logic         fault_o,
`endif
  output logic [N-1:0] pc_plus4_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_HOLD
`ifdef IF_MISALIGN_TRAP_EN
    , S_FAULT
`endif
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] tgt;
  logic         ld_en;
  logic [N-1:0] ld_val;

  // Trap build keeps the raw target so the misalignment is still visible when it is loaded.
`ifdef IF_MISALIGN_TRAP_EN
  assign tgt = redirect_pc_i;
`else
  assign tgt = {redirect_pc_i[N-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    ld_en   = 1'b0;
    ld_val  = tgt;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        ld_en   = redirect_i;
      end
      S_FETCH: begin
        if (imem_ready_i) begin
          if (redirect_i) ld_en = 1'b1;
          else begin
            instr_d = imem_rdata_i;
            state_d = S_HOLD;
          end
        end else if (redirect_i) begin
          pend_d  = tgt;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Address must stay put until the stale response lands; latest redirect wins.
        if (redirect_i) pend_d = tgt;
        if (imem_ready_i) begin
          ld_en   = 1'b1;
          ld_val  = redirect_i ? tgt : pend_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          ld_en   = 1'b1;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          pc_d    = pc_q + N'(4);
          state_d = S_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
    if (ld_en) begin
      pc_d = ld_val;
`ifdef IF_MISALIGN_TRAP_EN
      if (|ld_val[1:0]) state_d = S_FAULT;
`endif
    end
  end

  assign imem_req_o  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr_o = pc_q;
  assign valid_o     = (state_q == S_HOLD) && !redirect_i;
  assign instr_o     = valid_o ? instr_q : NOP_INSTR;
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + N'(4);
`ifdef IF_MISALIGN_TRAP_EN
  assign fault_o     = (state_q == S_FAULT);
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run checked against a fetch-stream model.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i, redirect_i, imem_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, pc_o, instr_o, pc_plus4_o;

  logic        w_stall = 1'b0, w_redirect = 1'b0, w_ready = 1'b1;
  logic [31:0] w_redirect_pc = 32'h0, w_rdata = 32'h12345678;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr, w_p4;
`ifdef IF_MISALIGN_TRAP_EN
  logic        fault_o, w_fault;
`endif

  int ntot = 0;
  int npass = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.N(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i), .valid_o(valid_o),
    .pc_o(pc_o), .instr_o(instr_o),
`ifdef IF_MISALIGN_TRAP_EN
    .fault_o(fault_o),
`endif
    .pc_plus4_o(pc_plus4_o)
  );

  if_fetch_unit #(.N(32), .RESET_PC(32'hFFFFFFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .reset(reset), .stall_i(w_stall), .redirect_i(w_redirect),
    .redirect_pc_i(w_redirect_pc), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(w_ready), .imem_rdata_i(w_rdata), .valid_o(w_valid),
    .pc_o(w_pc), .instr_o(w_instr),
`ifdef IF_MISALIGN_TRAP_EN
    .fault_o(w_fault),
`endif
    .pc_plus4_o(w_p4)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic idle_in();
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ready_i = 1'b0; imem_rdata_i = 32'h0;
  endtask

  // Leaves both DUTs in FETCH at RESET_PC, just after a falling edge.
  task automatic do_reset();
    idle_in();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b1; #1; reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    ntot++;
    if ({imem_req_o, valid_o, pc_o, instr_o, pc_plus4_o, imem_addr_o} !== {1'b0, 1'b0, 32'h0, NOP, 32'h4, 32'h0})
      $display("FAIL reset_outputs got req=%0b vld=%0b pc=%h instr=%h p4=%h addr=%h", imem_req_o, valid_o, pc_o, instr_o, pc_plus4_o, imem_addr_o);
    else npass++;
    ntot++;
    if ({w_pc, w_p4} !== {32'hFFFFFFFC, 32'h0})
      $display("FAIL reset_wrap_p4 got pc=%h p4=%h exp pc=fffffffc p4=0", w_pc, w_p4);
    else npass++;
`ifdef IF_MISALIGN_TRAP_EN
    ntot++;
    if (fault_o !== 1'b0) $display("FAIL reset_fault got=%0b exp=0", fault_o); else npass++;
`endif
    reset = 1'b1;
    #1;
    ntot++;
    if (imem_req_o !== 1'b0) $display("FAIL idle_req got=%0b exp=0", imem_req_o); else npass++;
    @(negedge clk); #1;
    ntot++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0})
      $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o);
    else npass++;
  endtask

  task automatic test_zero_wait();
    imem_ready_i = 1'b1; imem_rdata_i = 32'hAAAA0001;
    @(negedge clk);
    imem_ready_i = 1'b0; stall_i = 1'b0;
    #1;
    ntot++;
    if ({valid_o, instr_o, pc_o, pc_plus4_o} !== {1'b1, 32'hAAAA0001, 32'h0, 32'h4})
      $display("FAIL zw_hold got vld=%0b instr=%h pc=%h p4=%h", valid_o, instr_o, pc_o, pc_plus4_o);
    else npass++;
    @(negedge clk); #1;
    ntot++;
    if ({imem_req_o, imem_addr_o, valid_o} !== {1'b1, 32'h4, 1'b0})
      $display("FAIL zw_next got req=%0b addr=%h vld=%0b exp req=1 addr=4 vld=0", imem_req_o, imem_addr_o, valid_o);
    else npass++;
  endtask

  task automatic test_stall();
    imem_ready_i = 1'b1; imem_rdata_i = 32'hC0DE0004;
    @(negedge clk);
    imem_ready_i = 1'b0; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      ntot++;
      if ({valid_o, instr_o, pc_o, imem_req_o} !== {1'b1, 32'hC0DE0004, 32'h4, 1'b0})
        $display("FAIL stall_hold[%0d] got vld=%0b instr=%h pc=%h req=%0b", i, valid_o, instr_o, pc_o, imem_req_o);
      else npass++;
      @(negedge clk);
    end
    stall_i = 1'b0;
    @(negedge clk); #1;
    ntot++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8})
      $display("FAIL stall_release got req=%0b addr=%h exp req=1 addr=8", imem_req_o, imem_addr_o);
    else npass++;
  endtask

  task automatic test_drain();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0; #1;
    ntot++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8})
      $display("FAIL drain_hold_addr got req=%0b addr=%h exp req=1 addr=8", imem_req_o, imem_addr_o);
    else npass++;
    @(negedge clk);
    imem_ready_i = 1'b1; imem_rdata_i = 32'h0000DEAD; #1;
    ntot++;
    if ({imem_addr_o, valid_o} !== {32'h8, 1'b0})
      $display("FAIL drain_resp got addr=%h vld=%0b exp addr=8 vld=0", imem_addr_o, valid_o);
    else npass++;
    @(negedge clk);
    imem_ready_i = 1'b0; #1;
    ntot++;
    if ({imem_req_o, imem_addr_o, valid_o} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL drain_newaddr got req=%0b addr=%h vld=%0b exp addr=100", imem_req_o, imem_addr_o, valid_o);
    else npass++;
    redirect_i = 1'b1; redirect_pc_i = 32'h180;
    @(negedge clk);
    redirect_pc_i = 32'h200; #1;
    ntot++;
    if (imem_addr_o !== 32'h100) $display("FAIL drain2_hold got addr=%h exp=100", imem_addr_o); else npass++;
    @(negedge clk);
    redirect_i = 1'b0; imem_ready_i = 1'b1; imem_rdata_i = 32'h0000DEAD; #1;
    ntot++;
    if ({imem_addr_o, valid_o} !== {32'h100, 1'b0})
      $display("FAIL drain2_resp got addr=%h vld=%0b exp addr=100 vld=0", imem_addr_o, valid_o);
    else npass++;
    @(negedge clk);
    imem_ready_i = 1'b0; #1;
    ntot++;
    if (imem_addr_o !== 32'h200) $display("FAIL drain2_latest got addr=%h exp=200", imem_addr_o); else npass++;
`ifndef IF_MISALIGN_TRAP_EN
    imem_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h307;
    @(negedge clk);
    imem_ready_i = 1'b0; redirect_i = 1'b0; #1;
    ntot++;
    if (imem_addr_o !== 32'h304) $display("FAIL align_clear got addr=%h exp=304", imem_addr_o); else npass++;
`endif
  endtask

  task automatic test_hold_redirect();
    imem_ready_i = 1'b1; imem_rdata_i = 32'h11110000;
    @(negedge clk);
    imem_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40; #1;
    ntot++;
    if ({valid_o, instr_o} !== {1'b0, NOP})
      $display("FAIL hold_redirect_squash got vld=%0b instr=%h exp vld=0 instr=%h", valid_o, instr_o, NOP);
    else npass++;
    @(negedge clk);
    redirect_i = 1'b0; #1;
    ntot++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h40})
      $display("FAIL hold_redirect_addr got req=%0b addr=%h exp addr=40", imem_req_o, imem_addr_o);
    else npass++;
  endtask

  task automatic test_reset_mid();
    redirect_i = 1'b1; redirect_pc_i = 32'h500;
    @(negedge clk);
    redirect_i = 1'b0; #1;
    reset = 1'b0; #1;
    ntot++;
    if ({imem_req_o, imem_addr_o, valid_o, pc_o, instr_o, pc_plus4_o} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP, 32'h4})
      $display("FAIL reset_mid got req=%0b addr=%h vld=%0b pc=%h instr=%h p4=%h", imem_req_o, imem_addr_o, valid_o, pc_o, instr_o, pc_plus4_o);
    else npass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (w_valid) seen = 1'b1;
      else @(negedge clk);
    end
    ntot++;
    if (!seen) $display("FAIL wrap_timeout got no valid within 10 cycles");
    else if ({w_pc, w_p4} !== {32'hFFFFFFFC, 32'h0})
      $display("FAIL wrap_hold got pc=%h p4=%h exp pc=fffffffc p4=0", w_pc, w_p4);
    else npass++;
    @(negedge clk); #1;
    ntot++;
    if ({w_req, w_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_next got req=%0b addr=%h exp req=1 addr=0", w_req, w_addr);
    else npass++;
  endtask

`ifdef IF_MISALIGN_TRAP_EN
  task automatic test_fault();
    do_reset();
    imem_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h102;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      stall_i = 1'($urandom); imem_ready_i = 1'($urandom); redirect_i = 1'($urandom);
      redirect_pc_i = $urandom & 32'hFFFFFFFC;
      #1;
      ntot++;
      if ({fault_o, imem_req_o, valid_o, pc_o} !== {1'b1, 1'b0, 1'b0, 32'h102})
        $display("FAIL fault_sticky[%0d] got fault=%0b req=%0b vld=%0b pc=%h", i, fault_o, imem_req_o, valid_o, pc_o);
      else npass++;
      @(negedge clk);
    end
  endtask
`endif

  // Model: IF/ID must see the architectural fetch stream (sequential +4, jumping to each
  // redirect target word), with data equal to memory at that PC; requests hold their address.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] paddr = 32'h0;
    bit          pend = 1'b0;
    int          consumes = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stall_i       = ($urandom % 10) < 3;
      redirect_i    = ($urandom % 16) == 0;
      redirect_pc_i = $urandom;
`ifdef IF_MISALIGN_TRAP_EN
      redirect_pc_i[1:0] = 2'b00;
`endif
      imem_ready_i  = ($urandom % 10) < 6;
      imem_rdata_i  = imem_ready_i ? memfn(imem_addr_o) : $urandom;
      #1;
      if (pend) begin
        ntot++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, paddr})
          $display("FAIL rnd_addr_stable c=%0d got req=%0b addr=%h exp addr=%h", c, imem_req_o, imem_addr_o, paddr);
        else npass++;
      end
      if (redirect_i) begin
        ntot++;
        if (valid_o !== 1'b0) $display("FAIL rnd_squash c=%0d got vld=%0b exp=0", c, valid_o); else npass++;
        exp_pc = redirect_pc_i & 32'hFFFFFFFC;
      end else if (valid_o && !stall_i) begin
        ntot++;
        if ({pc_o, instr_o, pc_plus4_o} !== {exp_pc, memfn(exp_pc), exp_pc + 32'h4})
          $display("FAIL rnd_consume c=%0d got pc=%h instr=%h p4=%h exp pc=%h instr=%h", c, pc_o, instr_o, pc_plus4_o, exp_pc, memfn(exp_pc));
        else npass++;
        exp_pc = exp_pc + 32'h4;
        consumes++;
      end
      pend  = imem_req_o && !imem_ready_i;
      paddr = imem_addr_o;
      @(negedge clk);
    end
    ntot++;
    if (consumes < 50) $display("FAIL rnd_progress got consumes=%0d exp>=50", consumes); else npass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_drain();
    test_hold_redirect();
    test_reset_mid();
    test_wrap();
`ifdef IF_MISALIGN_TRAP_EN
    test_fault();
`endif
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
